// File: rtl/cipher_session_ctrl_if.sv
// Source and datapath handshake bundle for cipher_session_ctrl.
// The master side is the byte source plus grammar_fsm; the slave side is the controller.
interface cipher_session_ctrl_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       dp_rst;
   logic [7:0] dp_data;
   logic       dp_valid;
   logic       fsm_accept;
   logic       fsm_reject;

   modport master (output in_data, in_valid, fsm_accept, fsm_reject,
                   input  in_ready, dp_rst, dp_data, dp_valid);
   modport slave  (input  in_data, in_valid, fsm_accept, fsm_reject,
                   output in_ready, dp_rst, dp_data, dp_valid);
endinterface

// File: rtl/cipher_session_ctrl.sv
// Session sequencer for the xor_cipher -> grammar_fsm datapath.
// Define CIPHER_SESSION_STATS_EN to add saturating accept/reject/drop counters.
module cipher_session_ctrl #(
   parameter int unsigned MSG_LEN        = 3,
   parameter int unsigned TIMEOUT_CYCLES = 12000000,
   parameter int unsigned VERDICT_WAIT   = 8,
   parameter int unsigned HOLD_CYCLES    = 6000000,
   parameter int unsigned CNT_W          = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   cipher_session_ctrl_if.slave bus,
   output logic                 verdict_accept,
   output logic                 verdict_reject,
   output logic                 timeout_err,
   output logic                 busy,
   output logic [3:0]           byte_count
`ifdef CIPHER_SESSION_STATS_EN
   ,
   output logic [7:0]           stat_accept,
   output logic [7:0]           stat_reject,
   output logic [7:0]           stat_drop
`endif
);

   typedef enum logic [2:0] {CLEAR, IDLE, FEED, WAIT, HOLD} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] VWAIT_LAST   = CNT_W'(VERDICT_WAIT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(1);
   localparam logic [3:0]       LEN          = 4'(MSG_LEN);

   state_t           state;
   // Only one phase (clear, timeout, verdict wait, hold) runs at a time, so one counter serves all.
   logic [CNT_W-1:0] cnt;
   logic [3:0]       byte_next;

   assign byte_next = byte_count + 4'd1;

   // NOTE: every register here is updated with <= so all next-state terms read the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= CLEAR;
         cnt            <= '0;
         bus.dp_rst     <= 1'b1;
         bus.dp_valid   <= 1'b0;
         bus.dp_data    <= '0;
         bus.in_ready   <= 1'b0;
         verdict_accept <= 1'b0;
         verdict_reject <= 1'b0;
         timeout_err    <= 1'b0;
         byte_count     <= '0;
         busy           <= 1'b1;
      end else begin
         bus.dp_valid <= 1'b0;
         timeout_err  <= 1'b0;
         case (state)
            CLEAR: begin
               if (cnt == CLEAR_LAST) begin
                  state        <= IDLE;
                  cnt          <= '0;
                  bus.dp_rst   <= 1'b0;
                  bus.in_ready <= 1'b1;
                  busy         <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (bus.in_valid) begin
                  bus.dp_data  <= bus.in_data;
                  bus.dp_valid <= 1'b1;
                  byte_count   <= 4'd1;
                  cnt          <= '0;
                  busy         <= 1'b1;
                  if (MSG_LEN == 1) begin
                     state        <= WAIT;
                     bus.in_ready <= 1'b0;
                  end else begin
                     state <= FEED;
                  end
               end
            end
            FEED: begin
               if (bus.fsm_reject) begin
                  verdict_reject <= 1'b1;
                  state          <= HOLD;
                  bus.in_ready   <= 1'b0;
                  cnt            <= '0;
               end else if (bus.in_valid) begin
                  bus.dp_data  <= bus.in_data;
                  bus.dp_valid <= 1'b1;
                  byte_count   <= byte_next;
                  cnt          <= '0;
                  if (byte_next == LEN) begin
                     state        <= WAIT;
                     bus.in_ready <= 1'b0;
                  end
               end else if (cnt == TIMEOUT_LAST) begin
                  timeout_err    <= 1'b1;
                  verdict_reject <= 1'b1;
                  state          <= HOLD;
                  bus.in_ready   <= 1'b0;
                  cnt            <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT: begin
               // Reject has priority; a missing verdict is treated as a reject.
               if (bus.fsm_reject || (!bus.fsm_accept && cnt == VWAIT_LAST)) begin
                  verdict_reject <= 1'b1;
                  state          <= HOLD;
                  cnt            <= '0;
               end else if (bus.fsm_accept) begin
                  verdict_accept <= 1'b1;
                  state          <= HOLD;
                  cnt            <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state          <= CLEAR;
                  cnt            <= '0;
                  bus.dp_rst     <= 1'b1;
                  verdict_accept <= 1'b0;
                  verdict_reject <= 1'b0;
                  byte_count     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

`ifdef CIPHER_SESSION_STATS_EN
   // The first HOLD cycle is the only one with cnt == 0, so each session's verdict is counted once.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_accept <= '0;
         stat_reject <= '0;
         stat_drop   <= '0;
      end else begin
         if (state == HOLD && cnt == '0) begin
            if (verdict_accept && stat_accept != 8'hFF) stat_accept <= stat_accept + 8'd1;
            if (verdict_reject && stat_reject != 8'hFF) stat_reject <= stat_reject + 8'd1;
         end
         if (bus.in_valid && !bus.in_ready && stat_drop != 8'hFF)
            stat_drop <= stat_drop + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cipher_session_ctrl.sv
// Scoreboard bench for cipher_session_ctrl: forwarded bytes and verdicts are queued
// when stimulus is driven and compared when the controller produces them.
module tb_cipher_session_ctrl;
   localparam int MSG_LEN        = 3;
   localparam int TIMEOUT_CYCLES = 20;
   localparam int VERDICT_WAIT   = 8;
   localparam int HOLD_CYCLES    = 16;
   localparam int CNT_W          = 24;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       verdict_accept, verdict_reject, timeout_err, busy;
   logic [3:0] byte_count;
`ifdef CIPHER_SESSION_STATS_EN
   logic [7:0] stat_accept, stat_reject, stat_drop;
`endif

   cipher_session_ctrl_if bus ();

   cipher_session_ctrl #(
      .MSG_LEN(MSG_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .VERDICT_WAIT(VERDICT_WAIT),
      .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .verdict_accept(verdict_accept), .verdict_reject(verdict_reject),
      .timeout_err(timeout_err), .busy(busy), .byte_count(byte_count)
`ifdef CIPHER_SESSION_STATS_EN
      , .stat_accept(stat_accept), .stat_reject(stat_reject), .stat_drop(stat_drop)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] data; int cyc; } dp_exp_t;
   dp_exp_t    exp_dp[$];
   logic [1:0] exp_verdict[$];   // {accept, reject}

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit fwd);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      if (fwd) exp_dp.push_back('{b, cyc + 1});
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_verdict(input bit acc, input bit rej);
      bus.fsm_accept = acc;
      bus.fsm_reject = rej;
      tick();
      bus.fsm_accept = 1'b0;
      bus.fsm_reject = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (bus.in_ready && !busy) break;
         tick();
      end
      check("reach_idle", {30'd0, bus.in_ready, busy}, 32'h2);
   endtask

   // Runs out the hold window, then expects exactly two cycles of datapath reset.
   task automatic finish_session(input string tag);
      for (int i = 0; i < HOLD_CYCLES + 50; i++) begin
         if (!(verdict_accept || verdict_reject)) break;
         tick();
      end
      check({tag, "_clr1"}, {30'd0, bus.dp_rst, verdict_accept | verdict_reject}, 32'h2);
      tick();
      check({tag, "_clr2"}, {31'd0, bus.dp_rst}, 32'd1);
      tick();
      check({tag, "_idle"}, {30'd0, bus.dp_rst, bus.in_ready}, 32'h1);
   endtask

   // Forwarded-byte scoreboard: data and one-cycle latency.
   always @(negedge clk) begin
      if (bus.dp_valid) begin
         check("dp_valid_vs_dp_rst", {31'd0, bus.dp_rst}, 32'd0);
         if (exp_dp.size() == 0) begin
            check("dp_unexpected", 32'd1, 32'd0);
         end else begin
            dp_exp_t e;
            e = exp_dp.pop_front();
            check("dp_data", {24'd0, bus.dp_data}, {24'd0, e.data});
            check("dp_latency", cyc, e.cyc);
         end
      end
   end

   // Verdict scoreboard: value on assertion, duration on release.
   logic [1:0] prev_v = 2'b00;
   int         hold_len = 0;
   always @(negedge clk) begin
      logic [1:0] v;
      v = {verdict_accept, verdict_reject};
      if (prev_v == 2'b00 && v != 2'b00) begin
         if (exp_verdict.size() == 0) check("verdict_unexpected", {30'd0, v}, 32'd0);
         else check("verdict_value", {30'd0, v}, {30'd0, exp_verdict.pop_front()});
         hold_len = 0;
      end
      if (v != 2'b00) hold_len++;
      if (prev_v != 2'b00 && v == 2'b00 && !rst) check("verdict_hold_len", hold_len, HOLD_CYCLES);
      prev_v = v;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.in_data    = 8'h00;
      bus.in_valid   = 1'b0;
      bus.fsm_accept = 1'b0;
      bus.fsm_reject = 1'b0;

      // Reset values, then exactly two cycles of dp_rst after release.
      idle(2);
      check("rst_vals", {19'd0, bus.dp_rst, bus.dp_valid, bus.in_ready, verdict_accept,
                         verdict_reject, timeout_err, busy, byte_count, bus.dp_data == 8'h00},
            {19'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1});
      rst = 1'b0;
      tick();
      check("post_rst_clear1", {31'd0, bus.dp_rst}, 32'd1);
      tick();
      check("post_rst_idle", {29'd0, bus.dp_rst, bus.in_ready, busy}, 32'h2);

      // Accepting session, bytes spaced 10 cycles apart.
      exp_verdict.push_back(2'b10);
      send_byte(8'h9D, 1'b1); idle(9);
      send_byte(8'hEC, 1'b1); idle(9);
      send_byte(8'hEA, 1'b1);
      check("acc_wait", {27'd0, byte_count, bus.in_ready}, {27'd0, 4'd3, 1'b0});
      idle(2);
      pulse_verdict(1'b1, 1'b0);
      finish_session("acc");

      // Rejecting session.
      exp_verdict.push_back(2'b01);
      send_byte(8'h9D, 1'b1); idle(2);
      send_byte(8'hEC, 1'b1); idle(2);
      send_byte(8'h00, 1'b1); idle(1);
      pulse_verdict(1'b0, 1'b1);
      check("rej_count", {28'd0, byte_count}, 32'd3);
      finish_session("rej");

      // Inter-byte timeout.
      exp_verdict.push_back(2'b01);
      send_byte(8'h9D, 1'b1);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         n++;
         if (timeout_err) break;
      end
      check("timeout_cycle", n, TIMEOUT_CYCLES);
      tick();
      check("timeout_pulse_end", {30'd0, timeout_err, verdict_reject}, 32'h1);
      finish_session("tmo");

      // Early abort after the first byte; later bytes dropped.
      exp_verdict.push_back(2'b01);
      send_byte(8'h00, 1'b1);
      pulse_verdict(1'b0, 1'b1);
      check("abort_hold", {30'd0, verdict_reject, bus.in_ready}, 32'h2);
      send_byte(8'hEC, 1'b0); idle(1);
      send_byte(8'hEA, 1'b0); idle(1);
      check("abort_count", {28'd0, byte_count}, 32'd1);
`ifdef CIPHER_SESSION_STATS_EN
      check("stat_drop", {24'd0, stat_drop}, 32'd2);
      check("stat_acc_rej", {16'd0, stat_accept, stat_reject}, {16'd0, 8'd1, 8'd3});
`endif
      finish_session("abort");

      // Accept and reject together in WAIT: reject wins.
      exp_verdict.push_back(2'b01);
      send_byte(8'h9D, 1'b1);
      send_byte(8'hEC, 1'b1);
      send_byte(8'hEA, 1'b1);
      pulse_verdict(1'b1, 1'b1);
      finish_session("both");

      // No verdict at all: reject after VERDICT_WAIT cycles.
      exp_verdict.push_back(2'b01);
      send_byte(8'h9D, 1'b1);
      send_byte(8'hEC, 1'b1);
      send_byte(8'hEA, 1'b1);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         n++;
         if (verdict_reject || verdict_accept) break;
      end
      check("vwait_cycles", n, VERDICT_WAIT);
      finish_session("vwait");

      // Reset mid-session discards the partial session.
      send_byte(8'h9D, 1'b1); idle(2);
      send_byte(8'hEC, 1'b1); idle(2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst", {25'd0, bus.dp_rst, bus.dp_valid, bus.in_ready, busy, byte_count == 4'd0, verdict_accept, verdict_reject},
            {25'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      wait_idle();
      exp_verdict.push_back(2'b10);
      send_byte(8'h9D, 1'b1); idle(3);
      send_byte(8'hEC, 1'b1); idle(3);
      send_byte(8'hEA, 1'b1);
      pulse_verdict(1'b1, 1'b0);
      tick();
      check("fresh_accept", {30'd0, verdict_accept, verdict_reject}, 32'h2);
`ifdef CIPHER_SESSION_STATS_EN
      tick();
      check("stat_after_rst", {8'd0, stat_accept, stat_reject, stat_drop}, {8'd0, 8'd1, 8'd0, 8'd0});
`endif
      finish_session("fresh");

      check("dp_queue_empty", exp_dp.size(), 0);
      check("verdict_queue_empty", exp_verdict.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cipher_session_ctrl.md
Name: cipher_session_ctrl

Overview:
Sequences one message session through the xor_cipher → grammar_fsm datapath. Accepts encrypted bytes from an upstream source (UART receiver or hardcoded feeder) and forwards exactly MSG_LEN bytes per session. Collects the accept/reject verdict and holds it for display. Re-synchronises the cipher key index and the grammar FSM by pulsing their reset between sessions, and aborts stalled sessions on inter-byte timeout.

Parameters:
MSG_LEN, 3, bytes per session (1..15)
TIMEOUT_CYCLES, 12000000, max idle cycles between bytes inside a session
VERDICT_WAIT, 8, max cycles to wait for a verdict after the last byte
HOLD_CYCLES, 6000000, cycles the verdict is held on outputs
CNT_W, 24, width of the timeout and hold counters (must hold max of the above)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_data  in  8  encrypted byte from source
in_valid  in  1  single-cycle byte strobe
in_ready  out  1  high when a byte will be accepted this cycle
dp_rst  out  1  synchronous reset to xor_cipher and grammar_fsm
dp_data  out  8  byte to xor_cipher data_in
dp_valid  out  1  strobe to xor_cipher data_valid
fsm_accept  in  1  grammar_fsm accept
fsm_reject  in  1  grammar_fsm reject
verdict_accept  out  1  held accept, active-high
verdict_reject  out  1  held reject, active-high
timeout_err  out  1  one-cycle pulse on inter-byte timeout
busy  out  1  high whenever state != IDLE
byte_count  out  4  bytes forwarded in the current session

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: state=CLEAR, dp_rst=1, dp_valid=0, dp_data=0, in_ready=0, verdicts=0, timeout_err=0, byte_count=0, busy=1.
- States: CLEAR, IDLE, FEED, WAIT, HOLD.
- CLEAR:
  - dp_rst=1 for exactly 2 cycles, then IDLE.
  - Verdicts and byte_count cleared; in_ready=0.
- IDLE:
  - in_ready=1.
  - On in_valid: dp_data<=in_data and dp_valid=1 on the next cycle (1-cycle latency); byte_count<=1; timer cleared.
  - Next state is FEED, or WAIT if MSG_LEN==1.
- FEED:
  - in_ready=1. Each in_valid forwards the byte with the same 1-cycle latency, increments byte_count and clears the timer.
  - When byte_count reaches MSG_LEN on an accepted byte, go to WAIT the same cycle.
  - Timer increments on every cycle without in_valid. At TIMEOUT_CYCLES: timeout_err pulses 1 cycle, verdict_reject<=1, go to HOLD.
  - fsm_reject asserted: verdict_reject<=1, go to HOLD (early abort); a simultaneous in_valid is dropped.
  - fsm_accept asserted before the final byte is ignored.
- WAIT:
  - in_ready=0; counts up to VERDICT_WAIT cycles.
  - fsm_reject → verdict_reject<=1, go to HOLD.
  - fsm_accept alone → verdict_accept<=1, go to HOLD.
  - Both in the same cycle → reject wins.
  - No verdict by VERDICT_WAIT → verdict_reject<=1, go to HOLD.
- HOLD:
  - in_ready=0; verdict outputs held for HOLD_CYCLES, then go to CLEAR.
  - in_valid is dropped.
- Only one of verdict_accept / verdict_reject is ever high.
- in_valid while in_ready=0 is dropped, no side effect.
- rst mid-session: next cycle is CLEAR with reset values; any partial session is discarded.
- dp_valid never asserts while dp_rst=1.

Optional Feature:
CIPHER_SESSION_STATS_EN.
- Defined:
  - Adds outputs stat_accept[7:0], stat_reject[7:0], stat_drop[7:0], all saturating at 255 and cleared only by rst (not by CLEAR).
  - stat_accept and stat_reject increment on entry to HOLD with the matching verdict; timeouts count as rejects.
  - stat_drop increments per in_valid received while in_ready=0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Bytes 9D, EC, EA, 10 cycles apart, MSG_LEN=3 → dp_data shows 9D, EC, EA, each 1 cycle after its strobe; verdict_accept=1 for HOLD_CYCLES; then dp_rst=1 for 2 cycles.
- Bytes 9D, EC, 00 → verdict_reject=1, verdict_accept stays 0, byte_count=3.
- TIMEOUT_CYCLES=20, send 9D then nothing → timeout_err pulses on cycle 20 after the byte; verdict_reject=1; session ends via HOLD→CLEAR.
- fsm_reject forced after first byte 00 → HOLD entered that cycle; 2nd and 3rd bytes dropped; byte_count=1 (stat_drop=2 with CIPHER_SESSION_STATS_EN).
- In WAIT, drive fsm_accept and fsm_reject together → verdict_reject=1 only. Separately, no verdict for 8 cycles → verdict_reject=1.
- Assert rst after 2nd byte → next cycle state CLEAR, dp_rst=1, byte_count=0. A fresh 9D, EC, EA then yields verdict_accept=1.
